// File: rtl/bp_be_int_resolver.sv
// Integer-pipe result resolver: stages each result, raises branch-mispredict redirects and misaligned-target exceptions.
// Latency: outputs are combinational from a single stage register, one cycle after the input.
// Backpressure: an unaccepted redirect is held stable (busy_o) and squashes all younger input until redirect_ready_i.
// Optional feature macro: BP_BE_INT_RESOLVER_PERF_EN (branch / mispredict counters).
module bp_be_int_resolver #(
    parameter int vaddr_width_p = 39,
    parameter int data_width_p  = 66,
    parameter int rd_width_p    = 5
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     v_i,
    input  logic [data_width_p-1:0]  data_i,
    input  logic [rd_width_p-1:0]    rd_addr_i,
    input  logic [vaddr_width_p-1:0] pc_i,
    input  logic [vaddr_width_p-1:0] pred_npc_i,
    input  logic                     branch_i,
    input  logic                     btaken_i,
    input  logic [vaddr_width_p-1:0] npc_i,
    input  logic                     misaligned_i,
    output logic                     wb_v_o,
    output logic [data_width_p-1:0]  wb_data_o,
    output logic [rd_width_p-1:0]    wb_rd_addr_o,
    output logic                     redirect_v_o,
    input  logic                     redirect_ready_i,
    output logic [vaddr_width_p-1:0] redirect_npc_o,
    output logic                     redirect_taken_o,
    output logic                     exc_v_o,
    output logic [vaddr_width_p-1:0] exc_pc_o,
    output logic [vaddr_width_p-1:0] exc_tval_o,
    output logic                     busy_o
`ifdef BP_BE_INT_RESOLVER_PERF_EN
    ,
    output logic [31:0]              mispredict_cnt_o,
    output logic [31:0]              branch_cnt_o
`endif
);

    typedef enum logic {IDLE, PENDING} state_e;

    state_e                   state_r;
    logic                     v_r;
    logic [data_width_p-1:0]  data_r;
    logic [rd_width_p-1:0]    rd_addr_r;
    logic [vaddr_width_p-1:0] pc_r;
    logic [vaddr_width_p-1:0] pred_npc_r;
    logic                     branch_r;
    logic                     btaken_r;
    logic [vaddr_width_p-1:0] npc_r;
    logic                     misaligned_r;
    logic [vaddr_width_p-1:0] hold_npc_r;
    logic                     hold_taken_r;

    logic pending;
    logic mispredict;
    logic kill;

    assign pending    = (state_r == PENDING);
    assign exc_v_o    = v_r & misaligned_r;
    assign mispredict = v_r & branch_r & ~misaligned_r & (npc_r != pred_npc_r);
    // Anything arriving while the stage resolves a redirect or a trap is wrong-path.
    assign kill       = flush_i | mispredict | exc_v_o | pending;

    assign wb_v_o       = v_r & ~misaligned_r;
    assign wb_data_o    = data_r;
    assign wb_rd_addr_o = rd_addr_r;

    assign exc_pc_o   = exc_v_o ? pc_r  : '0;
    assign exc_tval_o = exc_v_o ? npc_r : '0;

    assign redirect_v_o     = pending | mispredict;
    assign redirect_npc_o   = pending ? hold_npc_r   : npc_r;
    assign redirect_taken_o = pending ? hold_taken_r : btaken_r;
    assign busy_o           = redirect_v_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r      <= IDLE;
            v_r          <= 1'b0;
            data_r       <= '0;
            rd_addr_r    <= '0;
            pc_r         <= '0;
            pred_npc_r   <= '0;
            branch_r     <= 1'b0;
            btaken_r     <= 1'b0;
            npc_r        <= '0;
            misaligned_r <= 1'b0;
            hold_npc_r   <= '0;
            hold_taken_r <= 1'b0;
        end else begin
            v_r <= v_i & ~kill;
            if (v_i) begin
                data_r       <= data_i;
                rd_addr_r    <= rd_addr_i;
                pc_r         <= pc_i;
                pred_npc_r   <= pred_npc_i;
                branch_r     <= branch_i;
                btaken_r     <= btaken_i;
                npc_r        <= npc_i;
                misaligned_r <= misaligned_i;
            end
            if (flush_i) begin
                state_r <= IDLE;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (mispredict && !redirect_ready_i) begin
                            state_r      <= PENDING;
                            hold_npc_r   <= npc_r;
                            hold_taken_r <= btaken_r;
                        end
                    end
                    PENDING: begin
                        if (redirect_ready_i) state_r <= IDLE;
                    end
                    default: state_r <= IDLE;
                endcase
            end
        end
    end

`ifdef BP_BE_INT_RESOLVER_PERF_EN
    // Counters survive flushes; only reset clears them.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            branch_cnt_o     <= '0;
            mispredict_cnt_o <= '0;
        end else begin
            if (v_r && branch_r) branch_cnt_o <= branch_cnt_o + 32'd1;
            if (mispredict)      mispredict_cnt_o <= mispredict_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bp_be_int_resolver.sv
// Randomized + directed bench for bp_be_int_resolver against a behavioural reference model.
module tb_bp_be_int_resolver;

    localparam int VA = 39;
    localparam int DW = 66;
    localparam int RW = 5;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b0, flush_i = 1'b0, v_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic [RW-1:0] rd_addr_i = '0;
    logic [VA-1:0] pc_i = '0, pred_npc_i = '0, npc_i = '0;
    logic          branch_i = 1'b0, btaken_i = 1'b0, misaligned_i = 1'b0;
    logic          redirect_ready_i = 1'b0;
    logic          wb_v_o, redirect_v_o, redirect_taken_o, exc_v_o, busy_o;
    logic [DW-1:0] wb_data_o;
    logic [RW-1:0] wb_rd_addr_o;
    logic [VA-1:0] redirect_npc_o, exc_pc_o, exc_tval_o;
`ifdef BP_BE_INT_RESOLVER_PERF_EN
    logic [31:0]   mispredict_cnt_o, branch_cnt_o;
`endif

    bp_be_int_resolver #(.vaddr_width_p(VA), .data_width_p(DW), .rd_width_p(RW)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i), .v_i(v_i),
        .data_i(data_i), .rd_addr_i(rd_addr_i), .pc_i(pc_i), .pred_npc_i(pred_npc_i),
        .branch_i(branch_i), .btaken_i(btaken_i), .npc_i(npc_i), .misaligned_i(misaligned_i),
        .wb_v_o(wb_v_o), .wb_data_o(wb_data_o), .wb_rd_addr_o(wb_rd_addr_o),
        .redirect_v_o(redirect_v_o), .redirect_ready_i(redirect_ready_i),
        .redirect_npc_o(redirect_npc_o), .redirect_taken_o(redirect_taken_o),
        .exc_v_o(exc_v_o), .exc_pc_o(exc_pc_o), .exc_tval_o(exc_tval_o), .busy_o(busy_o)
`ifdef BP_BE_INT_RESOLVER_PERF_EN
        , .mispredict_cnt_o(mispredict_cnt_o), .branch_cnt_o(branch_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    // Reference model: the one instruction sitting in the stage plus an outstanding-redirect record.
    typedef struct {
        bit            v;
        bit [DW-1:0]   data;
        bit [RW-1:0]   rd;
        bit [VA-1:0]   pc, pred, npc;
        bit            br, tk, mis;
    } instr_t;

    instr_t    m_stage = '{default: 0};
    bit        m_pend = 0;
    bit [VA-1:0] m_pend_npc = '0;
    bit        m_pend_tk = 0;
    int unsigned m_br_cnt = 0, m_mp_cnt = 0;

    function automatic bit m_mispredict();
        return m_stage.v && m_stage.br && !m_stage.mis && (m_stage.npc != m_stage.pred);
    endfunction

    function automatic bit m_exc();
        return m_stage.v && m_stage.mis;
    endfunction

    task automatic compare_all();
        bit rv;
        rv = m_pend || m_mispredict();
        check("wb_v", DW'(wb_v_o), DW'(m_stage.v && !m_stage.mis));
        check("wb_data", wb_data_o, m_stage.data);
        check("wb_rd", DW'(wb_rd_addr_o), DW'(m_stage.rd));
        check("redirect_v", DW'(redirect_v_o), DW'(rv));
        check("redirect_npc", DW'(redirect_npc_o), DW'(m_pend ? m_pend_npc : m_stage.npc));
        check("redirect_taken", DW'(redirect_taken_o), DW'(m_pend ? m_pend_tk : m_stage.tk));
        check("exc_v", DW'(exc_v_o), DW'(m_exc()));
        check("exc_pc", DW'(exc_pc_o), DW'(m_exc() ? m_stage.pc : '0));
        check("exc_tval", DW'(exc_tval_o), DW'(m_exc() ? m_stage.npc : '0));
        check("busy", DW'(busy_o), DW'(rv));
`ifdef BP_BE_INT_RESOLVER_PERF_EN
        check("branch_cnt", DW'(branch_cnt_o), DW'(m_br_cnt));
        check("mispredict_cnt", DW'(mispredict_cnt_o), DW'(m_mp_cnt));
`endif
    endtask

    // Advance the model by one clock using the inputs that were presented during the cycle.
    task automatic model_clock();
        bit mp, younger_ok;
        mp = m_mispredict();
        if (reset_i) begin
            m_stage = '{default: 0};
            m_pend = 0; m_pend_npc = '0; m_pend_tk = 0;
            m_br_cnt = 0; m_mp_cnt = 0;
            return;
        end
        if (m_stage.v && m_stage.br) m_br_cnt++;
        if (mp) m_mp_cnt++;
        younger_ok = !(flush_i || mp || m_exc() || m_pend);
        if (flush_i) m_pend = 0;
        else if (m_pend) m_pend = !redirect_ready_i;
        else if (mp && !redirect_ready_i) begin
            m_pend = 1; m_pend_npc = m_stage.npc; m_pend_tk = m_stage.tk;
        end
        if (v_i) begin
            m_stage.data = data_i; m_stage.rd = rd_addr_i; m_stage.pc = pc_i;
            m_stage.pred = pred_npc_i; m_stage.npc = npc_i; m_stage.br = branch_i;
            m_stage.tk = btaken_i; m_stage.mis = misaligned_i;
        end
        m_stage.v = v_i && younger_ok;
    endtask

    function automatic logic [VA-1:0] rand_va();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[VA-1:0];
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    // One cycle: drive just after a rising edge, compare at the falling edge, then clock the model.
    task automatic step(input logic v, input logic br, input logic tk, input logic mis,
                        input logic rdy, input logic fl, input logic rs,
                        input logic [VA-1:0] pc, input logic [VA-1:0] pred, input logic [VA-1:0] npc);
        logic [31:0] r;
        r = $urandom();
        v_i = v; branch_i = br; btaken_i = tk; misaligned_i = mis;
        redirect_ready_i = rdy; flush_i = fl; reset_i = rs;
        pc_i = pc; pred_npc_i = pred; npc_i = npc;
        data_i = rand_data(); rd_addr_i = r[RW-1:0];
        @(negedge clk_i);
        if (chk_en) compare_all();
        @(posedge clk_i);
        model_clock();
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 1'b0, 1'b0, rdy, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic mispredict_load(input logic [VA-1:0] npc, input logic [VA-1:0] pred);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 39'h8000_0000, pred, npc);
    endtask

    initial begin
        @(posedge clk_i);
        #1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0);
        chk_en = 1'b1;
        check("reset_wb_v", DW'(wb_v_o), '0);
        check("reset_redirect_v", DW'(redirect_v_o), '0);
        check("reset_busy", DW'(busy_o), '0);
        check("reset_exc_v", DW'(exc_v_o), '0);
        check("reset_wb_data", wb_data_o, '0);
        check("reset_redirect_npc", DW'(redirect_npc_o), '0);
        idle(1'b0);

        // Correct prediction
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 39'h8000_000c, 39'h8000_0010, 39'h8000_0010);
        check("ok_wb_v", DW'(wb_v_o), DW'(1'b1));
        check("ok_redirect_v", DW'(redirect_v_o), '0);
        check("ok_busy", DW'(busy_o), '0);

        // Mispredict with ready high; younger instruction in the redirect cycle is squashed
        mispredict_load(39'h8000_0040, 39'h8000_0004);
        check("mp_redirect_v", DW'(redirect_v_o), DW'(1'b1));
        check("mp_redirect_npc", DW'(redirect_npc_o), DW'(39'h8000_0040));
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 39'h8000_0004, 39'h8000_0008, 39'h8000_0008);
        check("mp_younger_wb_v", DW'(wb_v_o), '0);
        check("mp_after_redirect_v", DW'(redirect_v_o), '0);

        // Backpressure: ready low for 3 cycles, then accepted
        mispredict_load(39'h8000_0080, 39'h8000_0020);
        for (int i = 0; i < 4; i++) begin
            check("bp_redirect_v", DW'(redirect_v_o), DW'(1'b1));
            check("bp_busy", DW'(busy_o), DW'(1'b1));
            check("bp_redirect_npc", DW'(redirect_npc_o), DW'(39'h8000_0080));
            step(1'b1, 1'b0, 1'b0, 1'b0, (i == 3), 1'b0, 1'b0, rand_va(), '0, '0);
        end
        check("bp_done_busy", DW'(busy_o), '0);
        check("bp_done_wb_v", DW'(wb_v_o), '0);
        idle(1'b0);

        // Misaligned target
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 39'h100, 39'h104, 39'h102);
        check("mis_exc_v", DW'(exc_v_o), DW'(1'b1));
        check("mis_exc_pc", DW'(exc_pc_o), DW'(39'h100));
        check("mis_exc_tval", DW'(exc_tval_o), DW'(39'h102));
        check("mis_wb_v", DW'(wb_v_o), '0);
        check("mis_redirect_v", DW'(redirect_v_o), '0);
        idle(1'b0);

        // Flush, then reset, while a redirect is pending
        for (int k = 0; k < 2; k++) begin
            mispredict_load(39'h8000_0100, 39'h8000_0200);
            idle(1'b0);
            check("pend_busy", DW'(busy_o), DW'(1'b1));
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, (k == 0), (k == 1), rand_va(), '0, '0);
            check("kill_redirect_v", DW'(redirect_v_o), '0);
            check("kill_busy", DW'(busy_o), '0);
            check("kill_wb_v", DW'(wb_v_o), '0);
        end

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [VA-1:0] npc, pred;
            logic [31:0] r;
            r = $urandom();
            npc = rand_va();
            if (r[3:0] == 4'd0) npc[0] = 1'b1;
            pred = (r[5:4] == 2'd0) ? rand_va() : ((r[6]) ? npc : (npc ^ (39'h1 << r[12:7])));
            step(r[15:13] != 3'd0, r[16], r[17], r[21:18] == 4'd0, r[23:22] != 2'd0,
                 r[28:24] == 5'd0, r[31:25] == 7'd0, rand_va(), pred, npc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
